// File: rtl/video_timing_pkg.sv
// Shared timing constants, per-axis timing record and FSM encoding for the
// video timing generator.
package video_timing_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned CNT_W = 12;

   localparam int unsigned DEF_M0_H_SYNC  = 128;
   localparam int unsigned DEF_M0_H_BACK  = 88;
   localparam int unsigned DEF_M0_H_DISP  = 800;
   localparam int unsigned DEF_M0_H_FRONT = 40;
   localparam int unsigned DEF_M0_V_SYNC  = 4;
   localparam int unsigned DEF_M0_V_BACK  = 23;
   localparam int unsigned DEF_M0_V_DISP  = 600;
   localparam int unsigned DEF_M0_V_FRONT = 1;

   localparam int unsigned DEF_M1_H_SYNC  = 40;
   localparam int unsigned DEF_M1_H_BACK  = 220;
   localparam int unsigned DEF_M1_H_DISP  = 1280;
   localparam int unsigned DEF_M1_H_FRONT = 110;
   localparam int unsigned DEF_M1_V_SYNC  = 5;
   localparam int unsigned DEF_M1_V_BACK  = 20;
   localparam int unsigned DEF_M1_V_DISP  = 720;
   localparam int unsigned DEF_M1_V_FRONT = 5;

   typedef struct packed {
      logic [CNT_W-1:0] sync;
      logic [CNT_W-1:0] back;
      logic [CNT_W-1:0] disp;
      logic [CNT_W-1:0] front;
   } axis_t;

   function automatic axis_t make_axis(input int unsigned s, input int unsigned b,
                                       input int unsigned d, input int unsigned f);
      axis_t a;
      a.sync  = CNT_W'(s);
      a.back  = CNT_W'(b);
      a.disp  = CNT_W'(d);
      a.front = CNT_W'(f);
      return a;
   endfunction

   function automatic logic [CNT_W-1:0] axis_total(input axis_t a);
      return a.sync + a.back + a.disp + a.front;
   endfunction

endpackage

// File: rtl/video_hv_counter.sv
// Horizontal/vertical position counters with line-end and frame-end flags.
module video_hv_counter
   import video_timing_pkg::*;
(
   input  logic             pixel_clk,
   input  logic             sys_rst_n,
   input  logic             clear,
   input  logic [CNT_W-1:0] h_total,
   input  logic [CNT_W-1:0] v_total,
   output logic [CNT_W-1:0] h_cnt,
   output logic [CNT_W-1:0] v_cnt,
   output logic             line_end,
   output logic             frame_end
);

   assign line_end  = (h_cnt == h_total - CNT_W'(1));
   assign frame_end = line_end && (v_cnt == v_total - CNT_W'(1));

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (clear) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (line_end) begin
         h_cnt <= '0;
         v_cnt <= frame_end ? '0 : v_cnt + CNT_W'(1);
      end else begin
         h_cnt <= h_cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Two-mode video timing generator: run/idle FSM, mode latching at frame wrap
// and registered sync/valid/pixel-request outputs one cycle behind the counters.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned REQ_LEAD   = 2,
   parameter int unsigned HS_POL     = 1,
   parameter int unsigned VS_POL     = 1,
   parameter int unsigned M0_H_SYNC  = DEF_M0_H_SYNC,
   parameter int unsigned M0_H_BACK  = DEF_M0_H_BACK,
   parameter int unsigned M0_H_DISP  = DEF_M0_H_DISP,
   parameter int unsigned M0_H_FRONT = DEF_M0_H_FRONT,
   parameter int unsigned M0_V_SYNC  = DEF_M0_V_SYNC,
   parameter int unsigned M0_V_BACK  = DEF_M0_V_BACK,
   parameter int unsigned M0_V_DISP  = DEF_M0_V_DISP,
   parameter int unsigned M0_V_FRONT = DEF_M0_V_FRONT,
   parameter int unsigned M1_H_SYNC  = DEF_M1_H_SYNC,
   parameter int unsigned M1_H_BACK  = DEF_M1_H_BACK,
   parameter int unsigned M1_H_DISP  = DEF_M1_H_DISP,
   parameter int unsigned M1_H_FRONT = DEF_M1_H_FRONT,
   parameter int unsigned M1_V_SYNC  = DEF_M1_V_SYNC,
   parameter int unsigned M1_V_BACK  = DEF_M1_V_BACK,
   parameter int unsigned M1_V_DISP  = DEF_M1_V_DISP,
   parameter int unsigned M1_V_FRONT = DEF_M1_V_FRONT
) (
   input  logic              pixel_clk,
   input  logic              sys_rst_n,
   input  logic              show_en,
   input  logic              mode_sel,
   input  logic [DATA_W-1:0] pixel_data,
   output logic              pixel_req,
   output logic              img_hsync,
   output logic              img_vsync,
   output logic              img_valid,
   output logic [DATA_W-1:0] img_data,
   output logic [11:0]       pix_x,
   output logic [11:0]       pix_y,
   output logic              frame_start,
   output logic              busy
);

   localparam axis_t M0_H = make_axis(M0_H_SYNC, M0_H_BACK, M0_H_DISP, M0_H_FRONT);
   localparam axis_t M0_V = make_axis(M0_V_SYNC, M0_V_BACK, M0_V_DISP, M0_V_FRONT);
   localparam axis_t M1_H = make_axis(M1_H_SYNC, M1_H_BACK, M1_H_DISP, M1_H_FRONT);
   localparam axis_t M1_V = make_axis(M1_V_SYNC, M1_V_BACK, M1_V_DISP, M1_V_FRONT);
   localparam logic  HS_ON = (HS_POL != 0);
   localparam logic  VS_ON = (VS_POL != 0);

   state_t           state;
   logic             act_mode;
   axis_t            h_tim, v_tim;
   logic [CNT_W-1:0] h_cnt, v_cnt, h_lo, h_hi, v_lo, v_hi;
   logic [CNT_W:0]   h_lead;
   logic             line_end, frame_end;
   logic             h_act, v_act, valid_d, req_d, hsync_d, vsync_d, fs_d;

   assign h_tim = act_mode ? M1_H : M0_H;
   assign v_tim = act_mode ? M1_V : M0_V;

   video_hv_counter u_hv_counter (
      .pixel_clk (pixel_clk),
      .sys_rst_n (sys_rst_n),
      .clear     (state == IDLE),
      .h_total   (axis_total(h_tim)),
      .v_total   (axis_total(v_tim)),
      .h_cnt     (h_cnt),
      .v_cnt     (v_cnt),
      .line_end  (line_end),
      .frame_end (frame_end)
   );

   always_comb begin
      h_lo    = h_tim.sync + h_tim.back;
      h_hi    = h_lo + h_tim.disp;
      v_lo    = v_tim.sync + v_tim.back;
      v_hi    = v_lo + v_tim.disp;
      h_act   = (h_cnt >= h_lo) && (h_cnt < h_hi);
      v_act   = (v_cnt >= v_lo) && (v_cnt < v_hi);
      valid_d = h_act && v_act;
      // The request looks REQ_LEAD columns ahead on the same line; the lead
      // never exceeds sync+back, so no lookahead across a line wrap is needed.
      h_lead  = {1'b0, h_cnt} + (CNT_W+1)'(REQ_LEAD);
      req_d   = (h_lead >= {1'b0, h_lo}) && (h_lead < {1'b0, h_hi}) && v_act;
      hsync_d = (h_cnt < h_tim.sync) ? HS_ON : ~HS_ON;
      vsync_d = (v_cnt < v_tim.sync) ? VS_ON : ~VS_ON;
      fs_d    = (h_cnt == '0) && (v_cnt == '0);
   end

   assign busy = (state == RUN);

   always_ff @(posedge pixel_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state       <= IDLE;
         act_mode    <= 1'b0;
         pixel_req   <= 1'b0;
         img_hsync   <= ~HS_ON;
         img_vsync   <= ~VS_ON;
         img_valid   <= 1'b0;
         img_data    <= '0;
         pix_x       <= '0;
         pix_y       <= '0;
         frame_start <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               pixel_req   <= 1'b0;
               img_hsync   <= ~HS_ON;
               img_vsync   <= ~VS_ON;
               img_valid   <= 1'b0;
               img_data    <= '0;
               pix_x       <= '0;
               pix_y       <= '0;
               frame_start <= 1'b0;
               if (show_en) begin
                  state    <= RUN;
                  act_mode <= mode_sel;
               end
            end
            RUN: begin
               pixel_req   <= req_d;
               img_hsync   <= hsync_d;
               img_vsync   <= vsync_d;
               img_valid   <= valid_d;
               img_data    <= valid_d ? pixel_data : '0;
               pix_x       <= valid_d ? h_cnt - h_lo : '0;
               pix_y       <= valid_d ? v_cnt - v_lo : '0;
               frame_start <= fs_d;
               if (frame_end) begin
                  if (show_en) act_mode <= mode_sel;
                  else         state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized scoreboard bench: a frame-position model predicts every output
// cycle, a counter-pattern source answers pixel requests.
module tb_video_timing_gen;

   localparam int unsigned DW = 16;
   localparam int unsigned L  = 3;
   localparam int unsigned HP = 0;
   localparam int unsigned VP = 1;
   // mode timings: {h_sync, h_back, h_disp, h_front, v_sync, v_back, v_disp, v_front}
   localparam int T0[8] = '{4, 3, 10, 2, 2, 2, 6, 1};
   localparam int T1[8] = '{3, 4, 12, 3, 1, 3, 8, 2};

   typedef struct {
      logic          hs, vs, valid, req, fs, busy;
      logic [DW-1:0] data;
      logic [11:0]   x, y;
   } exp_t;

   logic          pixel_clk = 1'b0;
   logic          sys_rst_n = 1'b0;
   logic          show_en   = 1'b0;
   logic          mode_sel  = 1'b0;
   logic [DW-1:0] pixel_data = '0;
   logic          pixel_req, img_hsync, img_vsync, img_valid, frame_start, busy;
   logic [DW-1:0] img_data;
   logic [11:0]   pix_x, pix_y;

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];

   always #5 pixel_clk = ~pixel_clk;

   video_timing_gen #(
      .DATA_W(DW), .REQ_LEAD(L), .HS_POL(HP), .VS_POL(VP),
      .M0_H_SYNC(T0[0]), .M0_H_BACK(T0[1]), .M0_H_DISP(T0[2]), .M0_H_FRONT(T0[3]),
      .M0_V_SYNC(T0[4]), .M0_V_BACK(T0[5]), .M0_V_DISP(T0[6]), .M0_V_FRONT(T0[7]),
      .M1_H_SYNC(T1[0]), .M1_H_BACK(T1[1]), .M1_H_DISP(T1[2]), .M1_H_FRONT(T1[3]),
      .M1_V_SYNC(T1[4]), .M1_V_BACK(T1[5]), .M1_V_DISP(T1[6]), .M1_V_FRONT(T1[7])
   ) dut (
      .pixel_clk   (pixel_clk),
      .sys_rst_n   (sys_rst_n),
      .show_en     (show_en),
      .mode_sel    (mode_sel),
      .pixel_data  (pixel_data),
      .pixel_req   (pixel_req),
      .img_hsync   (img_hsync),
      .img_vsync   (img_vsync),
      .img_valid   (img_valid),
      .img_data    (img_data),
      .pix_x       (pix_x),
      .pix_y       (pix_y),
      .frame_start (frame_start),
      .busy        (busy)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic exp_t idle_exp();
      exp_t e;
      e.hs = (HP == 0); e.vs = (VP == 0);
      e.valid = 0; e.req = 0; e.fs = 0; e.busy = 0;
      e.data = '0; e.x = '0; e.y = '0;
      return e;
   endfunction

   function automatic int tim(input int mode, input int idx);
      return (mode != 0) ? T1[idx] : T0[idx];
   endfunction

   // Reference model: a running flag, the latched mode and a linear position
   // inside the frame; h/v are derived by division.
   initial begin : model
      int   running, mode, pos, ht, vt, h, v, hlo, vlo;
      bit   hact, vact;
      exp_t e;
      running = 0; mode = 0; pos = 0;
      forever begin
         @(posedge pixel_clk);
         if (!sys_rst_n) begin
            running = 0; mode = 0; pos = 0;
            q.push_back(idle_exp());
         end else begin
            e = idle_exp();
            ht = tim(mode, 0) + tim(mode, 1) + tim(mode, 2) + tim(mode, 3);
            vt = tim(mode, 4) + tim(mode, 5) + tim(mode, 6) + tim(mode, 7);
            if (running != 0) begin
               h = pos % ht; v = pos / ht;
               hlo = tim(mode, 0) + tim(mode, 1);
               vlo = tim(mode, 4) + tim(mode, 5);
               hact = (h >= hlo) && (h < hlo + tim(mode, 2));
               vact = (v >= vlo) && (v < vlo + tim(mode, 6));
               e.hs = (h < tim(mode, 0)) ? (HP != 0) : (HP == 0);
               e.vs = (v < tim(mode, 4)) ? (VP != 0) : (VP == 0);
               e.valid = hact && vact;
               e.req = vact && (h + L >= hlo) && (h + L < hlo + tim(mode, 2));
               e.fs = (pos == 0);
               e.x = e.valid ? 12'(h - hlo) : '0;
               e.y = e.valid ? 12'(v - vlo) : '0;
               e.data = e.valid ? DW'(h - hlo) : '0;
            end
            if (running == 0) begin
               if (show_en) begin running = 1; pos = 0; mode = int'(mode_sel); end
            end else if (pos == ht * vt - 1) begin
               pos = 0;
               if (show_en) mode = int'(mode_sel);
               else running = 0;
            end else begin
               pos++;
            end
            e.busy = (running != 0);
            q.push_back(e);
         end
      end
   end

   // Source: answers each request L-1 cycles later with its column index and
   // drives junk otherwise.
   initial begin : source
      logic hist[L+1];
      int   idx;
      idx = 0;
      for (int i = 0; i <= L; i++) hist[i] = 1'b0;
      forever begin
         @(negedge pixel_clk);
         for (int i = L; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = pixel_req;
         if (hist[L-1]) begin
            if (!hist[L]) idx = 0;
            pixel_data = DW'(idx);
            idx++;
         end else begin
            pixel_data = DW'($urandom);
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge pixel_clk);
         #1;
         if (q.size() == 0) begin
            chk("queue_underflow", 0, 1);
         end else begin
            e = q.pop_front();
            chk("img_hsync",   img_hsync,   e.hs);
            chk("img_vsync",   img_vsync,   e.vs);
            chk("img_valid",   img_valid,   e.valid);
            chk("pixel_req",   pixel_req,   e.req);
            chk("frame_start", frame_start, e.fs);
            chk("busy",        busy,        e.busy);
            chk("img_data",    img_data,    e.data);
            chk("pix_x",       pix_x,       e.x);
            chk("pix_y",       pix_y,       e.y);
         end
      end
   end

   initial begin : stimulus
      int waited;
      repeat (3) @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      @(negedge pixel_clk);
      show_en = 1'b1;
      repeat (300) @(negedge pixel_clk);
      mode_sel = 1'b1;
      repeat (700) @(negedge pixel_clk);
      for (int c = 0; c < 5000; c++) begin
         @(negedge pixel_clk);
         if ($urandom_range(0, 499) == 0) show_en = ~show_en;
         if ($urandom_range(0, 149) == 0) mode_sel = ~mode_sel;
      end
      show_en = 1'b1;
      waited = 0;
      do begin
         @(negedge pixel_clk);
         waited++;
      end while (!(busy && img_valid && pix_x == 12'd5) && waited < 2000);
      chk("wait_mid_line", int'(waited < 2000), 1);
      sys_rst_n = 1'b0;
      #1;
      chk("rst_busy",  busy,      0);
      chk("rst_valid", img_valid, 0);
      chk("rst_hsync", img_hsync, 1);
      chk("rst_vsync", img_vsync, 0);
      chk("rst_req",   pixel_req, 0);
      chk("rst_pix_x", pix_x,     0);
      @(negedge pixel_clk);
      sys_rst_n = 1'b1;
      repeat (400) @(negedge pixel_clk);
      show_en = 1'b0;
      repeat (400) @(negedge pixel_clk);
      chk("final_idle", busy, 0);
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
